// File: rtl/div_sequencer_if.sv
// Decode-to-divider request bus and divider-to-writeback result bus.
// master: decode/writeback side that drives requests; slave: the divide sequencer.
interface div_sequencer_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 4
);
  logic            div_start;
  logic [2:0]      div_op;
  logic [RD_W-1:0] rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            wb_ready;
  logic            stall;
  logic            busy;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output div_start, div_op, rd, rs1_val, rs2_val, flush, wb_ready,
    input  stall, busy, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  div_start, div_op, rd, rs1_val, rs2_val, flush, wb_ready,
    output stall, busy, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring DIV/DIVU/REM/REMU sequencer: result 34 cycles after accept (1 for special cases),
// held until wb_ready, stall covers the whole operation. DIV_EARLY_OUT_EN adds a |a|<|b| 1-cycle shortcut.
module div_sequencer #(
  parameter int XLEN = 32,
  parameter int RD_W = 4
) (
  input logic             clk,
  input logic             rst,
  div_sequencer_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic            is_rem_q, neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic            wb_valid_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic            signed_op, a_neg, b_neg, div_zero, ovf, early, special, accept;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN:0]   shifted, trial;
  logic            no_borrow;
  logic [XLEN-1:0] rem_d, quo_d, quo_fix, rem_fix;

  assign signed_op = ~bus.div_op[0];
  assign a_neg     = signed_op & bus.rs1_val[XLEN-1];
  assign b_neg     = signed_op & bus.rs2_val[XLEN-1];
  assign a_mag     = a_neg ? -bus.rs1_val : bus.rs1_val;
  assign b_mag     = b_neg ? -bus.rs2_val : bus.rs2_val;
  assign div_zero  = (bus.rs2_val == '0);
  assign ovf       = signed_op && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early     = !div_zero && (a_mag < b_mag);
`else
  assign early     = 1'b0;
`endif
  assign special   = div_zero | ovf | early;
  assign accept    = (state_q == IDLE) && bus.div_start && bus.div_op[2] && !bus.flush;

  // Results that bypass the iteration; bit 1 of funct3 selects remainder.
  always_comb begin
    special_res = '0;
    if (div_zero)  special_res = bus.div_op[1] ? bus.rs1_val : '1;
    else if (ovf)  special_res = bus.div_op[1] ? '0 : bus.rs1_val;
    else           special_res = bus.div_op[1] ? bus.rs1_val : '0;
  end

  // One restoring step: the top bit of the trial difference is the borrow.
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign trial     = shifted - {1'b0, dvsr_q};
  assign no_borrow = ~trial[XLEN];
  assign rem_d     = no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_d     = {quo_q[XLEN-2:0], no_borrow};
  assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix   = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      is_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          wb_rd_q   <= bus.rd;
          is_rem_q  <= bus.div_op[1];
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          quo_q     <= a_mag;
          rem_q     <= '0;
          dvsr_q    <= b_mag;
          count_q   <= '0;
          if (special) begin
            wb_data_q  <= special_res;
            wb_valid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            state_q    <= RUN;
          end
        end
        RUN: if (bus.flush) begin
          state_q <= IDLE;
        end else begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(XLEN-1)) state_q <= FIX;
        end
        FIX: if (bus.flush) begin
          state_q <= IDLE;
        end else begin
          wb_data_q  <= is_rem_q ? rem_fix : quo_fix;
          wb_valid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: if (bus.flush || bus.wb_ready) begin
          wb_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.stall    = ((state_q == IDLE) && bus.div_start && bus.div_op[2]) ||
                        ((state_q != IDLE) && !((state_q == DONE) && bus.wb_ready));
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed test-plan cases plus randomized ops against an arithmetic model.
module tb_div_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  div_sequencer_if #(.XLEN(32), .RD_W(4)) bus ();
  div_sequencer #(.XLEN(32), .RD_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Expected result straight from RISC-V M semantics using 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    la = op[0] ? longint'(a) : longint'($signed(a));
    lb = op[0] ? longint'(b) : longint'($signed(b));
    q  = la / lb;
    r  = la % lb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint la, lb;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    la = op[0] ? longint'(a) : longint'($signed(a));
    lb = op[0] ? longint'(b) : longint'($signed(b));
    if (la < 0) la = -la;
    if (lb < 0) lb = -lb;
`ifdef DIV_EARLY_OUT_EN
    if (la < lb) return 1;
`endif
    return 34;
  endfunction

  task automatic idle_inputs();
    bus.div_start = 1'b0;
    bus.div_op    = 3'b000;
    bus.rd        = 4'd0;
    bus.rs1_val   = 32'd0;
    bus.rs2_val   = 32'd0;
    bus.flush     = 1'b0;
    bus.wb_ready  = 1'b0;
  endtask

  // Issues one divide at the current cycle start and follows it through writeback.
  task automatic run_div(input string name, input logic [2:0] op, input logic [3:0] rdi,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
    int          lat_exp, cyc;
    logic [31:0] res_exp;
    bit          stall_bad, hold_bad;
    lat_exp = ref_latency(op, a, b);
    res_exp = ref_result(op, a, b);
    bus.div_start = 1'b1; bus.div_op = op; bus.rd = rdi;
    bus.rs1_val = a; bus.rs2_val = b; bus.wb_ready = 1'b0; bus.flush = 1'b0;
    smp();
    tests++;
    if (bus.stall !== 1'b1 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s accept: stall=%b busy=%b wb_valid=%b, want 1 0 0", name, bus.stall, bus.busy, bus.wb_valid);
    end
    adv();
    bus.div_start = 1'b0; bus.div_op = 3'($urandom); bus.rd = 4'($urandom);
    bus.rs1_val = $urandom; bus.rs2_val = $urandom;
    cyc = 1; stall_bad = 1'b0;
    forever begin
      smp();
      if (bus.wb_valid === 1'b1 || cyc >= 100) break;
      if (bus.stall !== 1'b1) stall_bad = 1'b1;
      adv();
      cyc++;
    end
    tests++;
    if (bus.wb_valid !== 1'b1 || cyc != lat_exp) begin
      fails++;
      $display("FAIL %s latency: wb_valid=%b at cycle %0d, want 1 at cycle %0d", name, bus.wb_valid, cyc, lat_exp);
      if (bus.wb_valid !== 1'b1) begin
        rst = 1'b1; adv(); rst = 1'b0; idle_inputs();
        return;
      end
    end
    tests++;
    if (bus.wb_data !== res_exp || bus.wb_rd !== rdi) begin
      fails++;
      $display("FAIL %s result: wb_data=%h wb_rd=%0d, want %h %0d", name, bus.wb_data, bus.wb_rd, res_exp, rdi);
    end
    tests++;
    if (stall_bad || bus.stall !== 1'b1) begin
      fails++;
      $display("FAIL %s stall: dropped before writeback (final %b), want 1", name, bus.stall);
    end
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      adv();
      smp();
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== res_exp || bus.wb_rd !== rdi || bus.stall !== 1'b1)
        hold_bad = 1'b1;
    end
    if (hold > 0) begin
      tests++;
      if (hold_bad) begin
        fails++;
        $display("FAIL %s hold: wb_valid=%b wb_data=%h wb_rd=%0d stall=%b, want 1 %h %0d 1",
                 name, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.stall, res_exp, rdi);
      end
    end
    adv();
    bus.wb_ready = 1'b1;
    smp();
    tests++;
    if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s release: stall=%b wb_valid=%b, want 0 1", name, bus.stall, bus.wb_valid);
    end
    adv();
    bus.wb_ready = 1'b0;
    smp();
    tests++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s after_wb: busy=%b wb_valid=%b, want 0 0", name, bus.busy, bus.wb_valid);
    end
    adv();
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0 ||
        bus.wb_rd !== 4'd0 || bus.wb_data !== 32'd0) begin
      fails++;
      $display("FAIL %s: stall=%b busy=%b wb_valid=%b wb_rd=%0d wb_data=%h, want all zero",
               name, bus.stall, bus.busy, bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    adv(); adv();
    smp();
    check_reset_outputs("reset");
    adv();
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_div("div_100_7",   3'b100, 4'd5, 32'd100, 32'd7, 0);
    run_div("rem_100_7",   3'b110, 4'd5, 32'd100, 32'd7, 0);
    run_div("div_m7_2",    3'b100, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("rem_m7_2",    3'b110, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("divu_m7_2",   3'b101, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_div("divu_by0",    3'b101, 4'd7, 32'd55, 32'd0, 0);
    run_div("remu_by0",    3'b111, 4'd7, 32'd55, 32'd0, 0);
    run_div("div_ovf",     3'b100, 4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("rem_ovf",     3'b110, 4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("rd0",         3'b111, 4'd0, 32'd1234, 32'd10, 0);
    run_div("small_a",     3'b100, 4'd9, 32'hFFFF_FFFE, 32'd9, 0);
    run_div("hold5",       3'b100, 4'd5, 32'd100, 32'd7, 5);
  endtask

  task automatic test_mul_ignored();
    for (int op = 0; op < 4; op++) begin
      bus.div_start = 1'b1; bus.div_op = 3'(op);
      bus.rs1_val = $urandom; bus.rs2_val = $urandom; bus.rd = 4'd6;
      smp();
      tests++;
      if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
        fails++;
        $display("FAIL mul_op%0d: stall=%b busy=%b wb_valid=%b, want 0 0 0", op, bus.stall, bus.busy, bus.wb_valid);
      end
      adv();
      bus.div_start = 1'b0;
      smp();
      tests++;
      if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
        fails++;
        $display("FAIL mul_after%0d: busy=%b wb_valid=%b, want 0 0", op, bus.busy, bus.wb_valid);
      end
      adv();
    end
  endtask

  // Start DIV 1000/3, then abort in cycle 10 by flush or by reset.
  task automatic test_abort(input bit use_rst);
    bus.div_start = 1'b1; bus.div_op = 3'b100; bus.rd = 4'd4;
    bus.rs1_val = 32'd1000; bus.rs2_val = 32'd3;
    adv();
    bus.div_start = 1'b0;
    for (int c = 1; c < 10; c++) adv();
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    smp();
    tests++;
    if (bus.busy !== 1'b1 || bus.wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_running: busy=%b wb_valid=%b, want 1 0", bus.busy, bus.wb_valid);
    end
    adv();
    rst = 1'b0; bus.flush = 1'b0;
    if (use_rst) begin
      smp();
      check_reset_outputs("rst_mid");
      adv();
    end else begin
      run_div("after_flush", 3'b101, 4'd2, 32'd9, 32'd3, 0);
    end
  endtask

  task automatic test_flush_edges();
    bus.div_start = 1'b1; bus.div_op = 3'b100; bus.rs1_val = 32'd50; bus.rs2_val = 32'd5;
    bus.flush = 1'b1;
    adv();
    bus.div_start = 1'b0; bus.flush = 1'b0;
    smp();
    tests++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: busy=%b wb_valid=%b, want 0 0", bus.busy, bus.wb_valid);
    end
    adv();
    bus.div_start = 1'b1; bus.div_op = 3'b101; bus.rs1_val = 32'd55; bus.rs2_val = 32'd0;
    adv();
    bus.div_start = 1'b0; bus.flush = 1'b1; bus.wb_ready = 1'b1;
    smp();
    tests++;
    if (bus.wb_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_done_pre: wb_valid=%b, want 1", bus.wb_valid);
    end
    adv();
    bus.flush = 1'b0; bus.wb_ready = 1'b0;
    smp();
    tests++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_done: busy=%b wb_valid=%b, want 0 0", bus.busy, bus.wb_valid);
    end
    adv();
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 30; n++) begin
      op = {1'b1, 2'($urandom_range(0, 3))};
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(201, 100000)); end
        5: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_div($sformatf("rand%0d", n), op, 4'($urandom), a, b, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_directed();
    test_mul_ignored();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_edges();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
